// File: rtl/move_input_conditioner.sv
// move_input_conditioner: synchronise, debounce and edge-detect five Go Board buttons into single-cycle strobes.
// Optional MOVE_AUTOREPEAT_EN adds per-direction auto-repeat while a button stays held.
module move_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 6250000,
  parameter int REPEAT_PERIOD   = 3125000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Switch_Up,
  input  logic       i_Switch_Down,
  input  logic       i_Switch_Left,
  input  logic       i_Switch_Right,
  input  logic       i_Switch_Start,
  output logic       o_Up_Mvt,
  output logic       o_Down_Mvt,
  output logic       o_Left_Mvt,
  output logic       o_Right_Mvt,
  output logic       o_Game_Start,
  output logic [4:0] o_Held
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic {IDLE, PRESSED} state_t;
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_param
    $error("move_input_conditioner: parameter out of range");
  end
  logic [4:0]    w_raw;
  logic [4:0]    w_held;
  logic [4:0]    r_meta, r_sync, r_deb, r_req;
  logic [CW-1:0] r_cnt [5];
  state_t        r_state [5];
`ifdef MOVE_AUTOREPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(RMAX);
  logic [TW-1:0] r_tmr [4];
  logic [3:0]    r_rep;
`endif
  assign w_raw = {i_Switch_Start, i_Switch_Right, i_Switch_Left, i_Switch_Down, i_Switch_Up};
  always_comb begin
    w_held = '0;
    for (int b = 0; b < 5; b++) w_held[b] = (r_state[b] == PRESSED);
  end
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_meta <= '0;
      r_sync <= '0;
      r_deb  <= '0;
      r_req  <= '0;
      for (int b = 0; b < 5; b++) begin
        r_cnt[b]   <= '0;
        r_state[b] <= IDLE;
      end
`ifdef MOVE_AUTOREPEAT_EN
      r_rep <= '0;
      for (int b = 0; b < 4; b++) r_tmr[b] <= '0;
`endif
    end else begin
      r_meta <= w_raw;
      r_sync <= r_meta;
      for (int b = 0; b < 5; b++) begin
        if (r_sync[b] == r_deb[b]) r_cnt[b] <= '0;
        else if (r_cnt[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_deb[b] <= ~r_deb[b];
          r_cnt[b] <= '0;
        end else r_cnt[b] <= r_cnt[b] + 1'b1;
        r_req[b] <= 1'b0;
        if (r_state[b] == IDLE) begin
          if (r_deb[b]) begin
            r_state[b] <= PRESSED;
            r_req[b]   <= 1'b1;
          end
        end else if (!r_deb[b]) r_state[b] <= IDLE;
      end
`ifdef MOVE_AUTOREPEAT_EN
      // Timer restarts on every press and release; first wait is the delay, then the period.
      for (int b = 0; b < 4; b++) begin
        if (r_state[b] == IDLE || !r_deb[b]) begin
          r_tmr[b] <= '0;
          r_rep[b] <= 1'b0;
        end else if (r_tmr[b] == (r_rep[b] ? TW'(REPEAT_PERIOD - 1) : TW'(REPEAT_DELAY - 1))) begin
          r_tmr[b] <= '0;
          r_rep[b] <= 1'b1;
          r_req[b] <= 1'b1;
        end else r_tmr[b] <= r_tmr[b] + 1'b1;
      end
`endif
    end
  end
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Up_Mvt     <= 1'b0;
      o_Down_Mvt   <= 1'b0;
      o_Left_Mvt   <= 1'b0;
      o_Right_Mvt  <= 1'b0;
      o_Game_Start <= 1'b0;
      o_Held       <= '0;
    end else begin
      o_Up_Mvt     <= r_req[0];
      o_Down_Mvt   <= r_req[1] & ~r_req[0];
      o_Left_Mvt   <= r_req[2] & ~|r_req[1:0];
      o_Right_Mvt  <= r_req[3] & ~|r_req[2:0];
      o_Game_Start <= r_req[4];
      o_Held       <= w_held;
    end
  end
endmodule

// File: tb/tb_move_input_conditioner.sv
// tb_move_input_conditioner: directed checks of debounce latency, glitch rejection, priority, reset and repeat.
module tb_move_input_conditioner;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, start = 1'b0;
  logic       o_up, o_down, o_left, o_right, o_start;
  logic [4:0] held;
  logic [4:0] mv;
  int         checks = 0;
  int         failures = 0;

  move_input_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut (
    .i_Clk(clk), .i_Rst(rst),
    .i_Switch_Up(up), .i_Switch_Down(down), .i_Switch_Left(left),
    .i_Switch_Right(right), .i_Switch_Start(start),
    .o_Up_Mvt(o_up), .o_Down_Mvt(o_down), .o_Left_Mvt(o_left),
    .o_Right_Mvt(o_right), .o_Game_Start(o_start), .o_Held(held)
  );

  assign mv = {o_start, o_right, o_left, o_down, o_up};
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    {up, down, left, right, start} = '0;
    repeat (15) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    up = 1'b1;
    tick();
    tick();
    checks++;
    if (mv !== 5'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b want=%b", mv, 5'b0);
    end
    checks++;
    if (held !== 5'b0) begin
      failures++;
      $display("FAIL reset_held got=%b want=%b", held, 5'b0);
    end
    up = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_up_press();
    up = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      if (c == 20) up = 1'b0;
      tick();
      checks++;
      if (mv !== ((c == 7) ? 5'b00001 : 5'b0)) begin
        failures++;
        $display("FAIL up_strobe cyc=%0d got=%b want=%b", c, mv, (c == 7) ? 5'b00001 : 5'b0);
      end
      checks++;
      if (held !== ((c >= 7 && c <= 26) ? 5'b00001 : 5'b0)) begin
        failures++;
        $display("FAIL up_held cyc=%0d got=%b want=%b", c, held, (c >= 7 && c <= 26) ? 5'b00001 : 5'b0);
      end
    end
    settle();
  endtask

  task automatic test_glitch();
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 5; c++) begin
        left = (c < 3);
        tick();
        checks++;
        if (mv !== 5'b0 || held !== 5'b0) begin
          failures++;
          $display("FAIL glitch rep=%0d cyc=%0d strobes=%b held=%b want=0", r, c, mv, held);
        end
      end
    end
    settle();
  endtask

  task automatic test_priority();
    up = 1'b1;
    right = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      tick();
      checks++;
      if (mv !== ((c == 7) ? 5'b00001 : 5'b0)) begin
        failures++;
        $display("FAIL priority cyc=%0d got=%b want=%b", c, mv, (c == 7) ? 5'b00001 : 5'b0);
      end
      checks++;
      if (held !== ((c >= 7) ? 5'b01001 : 5'b0)) begin
        failures++;
        $display("FAIL priority_held cyc=%0d got=%b want=%b", c, held, (c >= 7) ? 5'b01001 : 5'b0);
      end
    end
    settle();
    down = 1'b1;
    left = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      tick();
      checks++;
      if (mv !== ((c == 7) ? 5'b00010 : 5'b0)) begin
        failures++;
        $display("FAIL priority_dl cyc=%0d got=%b want=%b", c, mv, (c == 7) ? 5'b00010 : 5'b0);
      end
    end
    settle();
    left = 1'b1;
    right = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      tick();
      checks++;
      if (mv !== ((c == 7) ? 5'b00100 : 5'b0)) begin
        failures++;
        $display("FAIL priority_lr cyc=%0d got=%b want=%b", c, mv, (c == 7) ? 5'b00100 : 5'b0);
      end
    end
    settle();
  endtask

  task automatic test_start_with_move();
    start = 1'b1;
    right = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      tick();
      checks++;
      if (mv !== ((c == 7) ? 5'b11000 : 5'b0)) begin
        failures++;
        $display("FAIL start_move cyc=%0d got=%b want=%b", c, mv, (c == 7) ? 5'b11000 : 5'b0);
      end
    end
    settle();
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (mv !== 5'b0) begin
        failures++;
        $display("FAIL rst_mid_pre cyc=%0d got=%b want=%b", c, mv, 5'b0);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (mv !== 5'b0 || held !== 5'b0) begin
      failures++;
      $display("FAIL rst_mid_clear strobes=%b held=%b want=0", mv, held);
    end
    for (int n = 0; n <= 20; n++) begin
      tick();
      checks++;
      if (mv !== ((n == 7) ? 5'b10000 : 5'b0)) begin
        failures++;
        $display("FAIL rst_mid_start cyc=%0d got=%b want=%b", n, mv, (n == 7) ? 5'b10000 : 5'b0);
      end
      checks++;
      if (held !== ((n >= 7) ? 5'b10000 : 5'b0)) begin
        failures++;
        $display("FAIL rst_mid_held cyc=%0d got=%b want=%b", n, held, (n >= 7) ? 5'b10000 : 5'b0);
      end
    end
    settle();
  endtask

  task automatic test_down_hold();
    logic exp;
    down = 1'b1;
    for (int c = 0; c <= 60; c++) begin
      if (c == 40) down = 1'b0;
      tick();
`ifdef MOVE_AUTOREPEAT_EN
      exp = (c == 7 || c == 17 || c == 22 || c == 27 || c == 32 || c == 37 || c == 42);
`else
      exp = (c == 7);
`endif
      checks++;
      if (mv !== {3'b0, exp, 1'b0}) begin
        failures++;
        $display("FAIL down_hold cyc=%0d got=%b want=%b", c, mv, {3'b0, exp, 1'b0});
      end
      checks++;
      if (held !== ((c >= 7 && c <= 46) ? 5'b00010 : 5'b0)) begin
        failures++;
        $display("FAIL down_held cyc=%0d got=%b want=%b", c, held, (c >= 7 && c <= 46) ? 5'b00010 : 5'b0);
      end
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_up_press();
    test_glitch();
    test_priority();
    test_start_with_move();
    test_reset_mid();
    test_down_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
